// File: rtl/lcd_sig_gen_pkg.sv
// Shared types and default geometry for the Game Boy LCD signal generator.
// Geometry defaults match the DMG panel: 160x144 with the usual blanking lengths.
package lcd_pkg;

  localparam int unsigned PX_PER_LINE_DEF = 160;
  localparam int unsigned LINES_DEF       = 144;
  localparam int unsigned HBLANK_CYC_DEF  = 16;
  localparam int unsigned VBLANK_CYC_DEF  = 4560;
  localparam int unsigned IDLE_W          = 16;

  typedef logic [1:0] px_code_t;

  typedef enum logic [3:0] {
    ST_OFF,
    ST_H_ST,
    ST_H_LOAD,
    ST_H_HOLD,
    ST_P_LOAD,
    ST_P_HI,
    ST_L_LOAD,
    ST_L_HI,
    ST_L_FALL,
    ST_HBLANK,
    ST_VBLANK
  } lcd_state_e;

endpackage

// File: rtl/lcd_sig_gen_if.sv
// Pixel stream from the PPU into the LCD signal generator.
// A pixel moves on a clock edge where px_valid & px_ready are both high; px_ready
// depends only on the consumer's state, and px_valid may toggle freely while px_ready=0.
interface lcd_sig_gen_if;
  import lcd_pkg::*;

  logic     px_valid;
  px_code_t px_data;
  logic     px_ready;

  modport master (output px_valid, output px_data, input px_ready);
  modport slave  (input px_valid, input px_data, output px_ready);
endinterface

// File: rtl/lcd_sig_gen.sv
// Converts the 2-bit pixel stream into registered Game Boy LCD connector signals
// (hsync, vsync, latch, altsig, ctrl, pclk, px) with a fixed per-line edge order.
module lcd_sig_gen
  import lcd_pkg::*;
#(
  parameter int unsigned PX_PER_LINE = PX_PER_LINE_DEF,
  parameter int unsigned LINES       = LINES_DEF,
  parameter int unsigned HBLANK_CYC  = HBLANK_CYC_DEF,
  parameter int unsigned VBLANK_CYC  = VBLANK_CYC_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         lcd_on,
  lcd_sig_gen_if.slave px_s,
  output logic         hsync,
  output logic         vsync,
  output logic         latch,
  output logic         altsig,
  output logic         ctrl,
  output logic         pclk,
  output px_code_t     px,
  output logic [7:0]   line,
  output logic         frame_done,
  output lcd_state_e   dbg_state
);

  localparam logic [7:0]        CNT_LAST  = 8'(PX_PER_LINE - 2);
  localparam logic [7:0]        LINE_LAST = 8'(LINES - 1);
  localparam logic [IDLE_W-1:0] HB_LAST   = IDLE_W'(HBLANK_CYC - 1);
  localparam logic [IDLE_W-1:0] VB_LAST   = IDLE_W'(VBLANK_CYC - 1);

  lcd_state_e        state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [7:0]        line_q, line_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              altsig_q, altsig_d;
  px_code_t          px_q, px_d;
  logic              hsync_q, hsync_d, vsync_q, vsync_d, latch_q, latch_d;
  logic              ctrl_q, ctrl_d, pclk_q, pclk_d, frame_done_q, frame_done_d;
  logic              rdy, xfer;

  assign rdy           = (state_q == ST_H_LOAD) || (state_q == ST_P_LOAD) ||
                         (state_q == ST_L_LOAD);
  assign px_s.px_ready = rdy;
  assign xfer          = rdy & px_s.px_valid;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    line_d       = line_q;
    idle_d       = idle_q;
    altsig_d     = altsig_q;
    px_d         = px_q;
    frame_done_d = 1'b0;
    case (state_q)
      ST_OFF: if (lcd_on) begin
        state_d  = ST_H_ST;
        line_d   = 8'd0;
        altsig_d = 1'b0;
      end
      ST_H_ST:   state_d = ST_H_LOAD;
      ST_H_LOAD: if (xfer) begin
        px_d    = px_s.px_data;
        state_d = ST_H_HOLD;
      end
      ST_H_HOLD: begin
        state_d = ST_P_LOAD;
        cnt_d   = 8'd1;
      end
      ST_P_LOAD: if (xfer) begin
        px_d    = px_s.px_data;
        state_d = ST_P_HI;
      end
      // The last middle pixel still needs its own pclk fall, which L_LOAD provides.
      ST_P_HI: if (cnt_q == CNT_LAST) begin
        state_d = ST_L_LOAD;
      end else begin
        state_d = ST_P_LOAD;
        cnt_d   = cnt_q + 8'd1;
      end
      ST_L_LOAD: if (xfer) begin
        px_d    = px_s.px_data;
        state_d = ST_L_HI;
      end
      ST_L_HI: begin
        state_d  = ST_L_FALL;
        altsig_d = ~altsig_q;
      end
      ST_L_FALL: begin
        state_d = ST_HBLANK;
        idle_d  = '0;
      end
      ST_HBLANK: if (idle_q == HB_LAST) begin
        idle_d = '0;
        if (line_q == LINE_LAST) begin
          state_d      = ST_VBLANK;
          frame_done_d = 1'b1;
        end else begin
          state_d = ST_H_ST;
          line_d  = line_q + 8'd1;
        end
      end else begin
        idle_d = idle_q + 1'b1;
      end
      ST_VBLANK: if (idle_q == VB_LAST) begin
        idle_d  = '0;
        line_d  = 8'd0;
        state_d = ST_H_ST;
      end else begin
        idle_d = idle_q + 1'b1;
      end
      default: state_d = ST_OFF;
    endcase
    if (!lcd_on) begin
      state_d      = ST_OFF;
      cnt_d        = 8'd0;
      line_d       = 8'd0;
      idle_d       = '0;
      altsig_d     = 1'b0;
      px_d         = 2'd0;
      frame_done_d = 1'b0;
    end
    // Strobes are decoded from the next state so every output is a flop.
    hsync_d = (state_d == ST_H_ST) || (state_d == ST_H_LOAD) || (state_d == ST_H_HOLD);
    pclk_d  = (state_d == ST_H_ST) || (state_d == ST_P_HI);
    latch_d = (state_d == ST_L_HI);
    ctrl_d  = (state_d != ST_OFF);
    vsync_d = (line_d == 8'd0) &&
              (hsync_d || ((state_d == ST_P_LOAD) && (cnt_d == 8'd1)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_OFF;
      cnt_q        <= 8'd0;
      line_q       <= 8'd0;
      idle_q       <= '0;
      altsig_q     <= 1'b0;
      px_q         <= 2'd0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      latch_q      <= 1'b0;
      ctrl_q       <= 1'b0;
      pclk_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      idle_q       <= idle_d;
      altsig_q     <= altsig_d;
      px_q         <= px_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      latch_q      <= latch_d;
      ctrl_q       <= ctrl_d;
      pclk_q       <= pclk_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign latch      = latch_q;
  assign altsig     = altsig_q;
  assign ctrl       = ctrl_q;
  assign pclk       = pclk_q;
  assign px         = px_q;
  assign line       = line_q;
  assign frame_done = frame_done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_lcd_sig_gen.sv
// Directed bench for lcd_sig_gen: default geometry plus a minimal N=3 instance.
module tb_lcd_sig_gen;
  import lcd_pkg::*;

  typedef struct {
    int          c;
    logic [16:0] exp;
  } vec_t;

  logic clk, reset, lcd_on, lcd_on3;
  int   n_checks, n_err;

  lcd_sig_gen_if px_if ();
  lcd_sig_gen_if px3_if ();

  logic hsync, vsync, latch, altsig, ctrl, pclk, frame_done;
  px_code_t px;
  logic [7:0] line;
  lcd_state_e dbg_state;

  logic hsync3, vsync3, latch3, altsig3, ctrl3, pclk3, frame_done3;
  px_code_t px3;
  logic [7:0] line3;
  lcd_state_e dbg_state3;

  lcd_sig_gen dut (
    .clk(clk), .reset(reset), .lcd_on(lcd_on), .px_s(px_if),
    .hsync(hsync), .vsync(vsync), .latch(latch), .altsig(altsig), .ctrl(ctrl),
    .pclk(pclk), .px(px), .line(line), .frame_done(frame_done), .dbg_state(dbg_state)
  );

  lcd_sig_gen #(.PX_PER_LINE(3), .LINES(2), .HBLANK_CYC(1), .VBLANK_CYC(3)) dut3 (
    .clk(clk), .reset(reset), .lcd_on(lcd_on3), .px_s(px3_if),
    .hsync(hsync3), .vsync(vsync3), .latch(latch3), .altsig(altsig3), .ctrl(ctrl3),
    .pclk(pclk3), .px(px3), .line(line3), .frame_done(frame_done3),
    .dbg_state(dbg_state3)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: counting stream, with one optional 20-cycle stall
  logic [1:0] exp_q[$];
  int seq;
  int stall_at;
  int stall_left;
  bit stall_done;

  initial begin : driver
    bit xfer;
    seq = 0; stall_at = -1; stall_left = 0; stall_done = 0;
    px_if.px_valid = 1'b1;
    px_if.px_data  = 2'd0;
    forever begin
      @(negedge clk);
      xfer = px_if.px_valid && px_if.px_ready;
      @(posedge clk);
      #1;
      if (xfer) begin
        exp_q.push_back(px_if.px_data);
        seq++;
        px_if.px_data = seq[1:0];
        if (seq == stall_at && !stall_done) begin
          stall_left = 20;
          stall_done = 1;
        end
      end
      if (stall_left > 0) begin
        px_if.px_valid = 1'b0;
        stall_left--;
      end else begin
        px_if.px_valid = 1'b1;
      end
    end
  end

  initial begin : driver3
    bit xfer;
    px3_if.px_valid = 1'b1;
    px3_if.px_data  = 2'd0;
    forever begin
      @(negedge clk);
      xfer = px3_if.px_valid && px3_if.px_ready;
      @(posedge clk);
      #1;
      if (xfer) px3_if.px_data = px3_if.px_data + 2'd1;
    end
  end

  // scoreboard monitor: every clock-in edge must present the next sent pixel
  logic prev_hs, prev_pc, prev_la;
  int   line_px, latch_cnt, fd_cnt;
  logic exp_alt;

  initial begin
    prev_hs = 0; prev_pc = 0; prev_la = 0;
    line_px = 0; latch_cnt = 0; fd_cnt = 0; exp_alt = 0;
  end

  always @(negedge clk) begin
    if (!ctrl) begin
      exp_alt   = 1'b0;
      latch_cnt = 0;
      fd_cnt    = 0;
    end else begin
      if (hsync && !prev_hs) line_px = 0;
      if ((prev_hs && !hsync) || (prev_pc && !pclk && !hsync) || (prev_la && !latch)) begin
        if (exp_q.size() == 0) chk("sb_empty", 32'(line_px), 32'hFFFF);
        else chk("sb_pixel", 32'(px), 32'(exp_q.pop_front()));
        line_px++;
      end
      if (prev_la && !latch) begin
        chk("line_px", line_px, 160);
        exp_alt = ~exp_alt;
        chk("altsig", 32'(altsig), 32'(exp_alt));
      end
      if (latch && !prev_la) latch_cnt++;
      if (frame_done) fd_cnt++;
      if (vsync) chk("vsync_line", 32'(line), 0);
    end
    prev_hs = hsync;
    prev_pc = pclk;
    prev_la = latch;
  end

  logic [16:0] got_v;
  assign got_v = {hsync, vsync, pclk, latch, px_if.px_ready, ctrl, altsig, px, line};

  function automatic vec_t mk(int c, logic hs, logic vs, logic pc, logic la, logic rdy,
                              logic ctl, logic alt, logic [1:0] p, logic [7:0] ln);
    vec_t v;
    v.c   = c;
    v.exp = {hs, vs, pc, la, rdy, ctl, alt, p, ln};
    return v;
  endfunction

  vec_t vecs[19];
  logic hs_h[0:14], pc_h[0:14], la_h[0:14];
  logic [1:0] px_h[0:14];

  initial begin : main
    int vi, n;
    bit found;
    int hs_f, pc_f, la_f, hs_r;
    n_checks = 0; n_err = 0;
    reset = 1'b1; lcd_on = 1'b0; lcd_on3 = 1'b0;

    vecs[0]  = mk(1,   1,1,1,0,0,1,0,2'd0,8'd0);
    vecs[1]  = mk(2,   1,1,0,0,1,1,0,2'd0,8'd0);
    vecs[2]  = mk(3,   1,1,0,0,0,1,0,2'd0,8'd0);
    vecs[3]  = mk(4,   0,1,0,0,1,1,0,2'd0,8'd0);
    vecs[4]  = mk(5,   0,0,1,0,0,1,0,2'd1,8'd0);
    vecs[5]  = mk(6,   0,0,0,0,1,1,0,2'd1,8'd0);
    vecs[6]  = mk(7,   0,0,1,0,0,1,0,2'd2,8'd0);
    vecs[7]  = mk(8,   0,0,0,0,1,1,0,2'd2,8'd0);
    vecs[8]  = mk(9,   0,0,1,0,0,1,0,2'd3,8'd0);
    vecs[9]  = mk(317, 0,0,1,0,0,1,0,2'd1,8'd0);
    vecs[10] = mk(318, 0,0,0,0,1,1,0,2'd1,8'd0);
    vecs[11] = mk(319, 0,0,1,0,0,1,0,2'd2,8'd0);
    vecs[12] = mk(320, 0,0,0,0,1,1,0,2'd2,8'd0);
    vecs[13] = mk(321, 0,0,0,1,0,1,0,2'd3,8'd0);
    vecs[14] = mk(322, 0,0,0,0,0,1,1,2'd3,8'd0);
    vecs[15] = mk(323, 0,0,0,0,0,1,1,2'd3,8'd0);
    vecs[16] = mk(338, 0,0,0,0,0,1,1,2'd3,8'd0);
    vecs[17] = mk(339, 1,0,1,0,0,1,1,2'd3,8'd1);
    vecs[18] = mk(340, 1,0,0,0,1,1,1,2'd3,8'd1);

    // reset state
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({got_v, frame_done}), 0);
    reset = 1'b0;
    @(negedge clk);
    chk("off_outputs", 32'({got_v, frame_done}), 0);

    // first line, table-driven
    lcd_on = 1'b1;
    vi = 0;
    for (int c = 1; c <= 340; c++) begin
      @(negedge clk);
      if (vi < 19 && vecs[vi].c == c) begin
        chk($sformatf("vec_c%0d", c), 32'(got_v), 32'(vecs[vi].exp));
        vi++;
      end
    end

    // stall before pixel 80 of line 1
    stall_at = 240;
    found = 0;
    for (int i = 0; i < 1000 && !found; i++) begin
      @(negedge clk);
      if (!px_if.px_valid) found = 1;
    end
    chk("stall_seen", 32'(found), 1);
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      chk("stall_hold", 32'({px_if.px_ready, pclk, px}), 32'({1'b1, 1'b0, 2'd3}));
    end
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (px_if.px_valid) found = 1;
    end
    @(negedge clk);
    chk("stall_resume", 32'({found, pclk, px}), 32'({1'b1, 1'b1, 2'd0}));

    // full frame
    found = 0;
    for (int i = 0; i < 60000 && !found; i++) begin
      @(negedge clk);
      if (frame_done) found = 1;
    end
    #1;
    chk("frame_done_seen", 32'(found), 1);
    chk("latch_pulses", latch_cnt, 144);
    n = 0;
    found = 0;
    for (int i = 0; i < 6000 && !found; i++) begin
      @(negedge clk);
      n++;
      if (hsync && pclk) found = 1;
    end
    #1;
    chk("vblank_len", n, 4560);
    chk("frame2_start", 32'({vsync, line}), 32'({1'b1, 8'd0}));
    chk("frame_done_count", fd_cnt, 1);

    // lcd_on dropped at pixel 50
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      #1;
      if (line_px == 50) found = 1;
    end
    chk("px50_seen", 32'(found), 1);
    lcd_on = 1'b0;
    @(negedge clk);
    chk("drop_off", 32'({got_v, frame_done}), 0);
    exp_q.delete();
    @(negedge clk);
    lcd_on = 1'b1;
    @(negedge clk);
    chk("reenable", 32'({hsync, vsync, pclk, altsig, line}), 32'({4'b1110, 8'd0}));

    // reset during L_HI
    found = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (latch) found = 1;
    end
    chk("l_hi_seen", 32'(found), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("reset_in_l_hi", 32'({latch, altsig, ctrl, hsync, pclk, px_if.px_ready}), 0);
    reset = 1'b0;
    exp_q.delete();
    repeat (5) @(negedge clk);

    // N=3 instance: edge order and line period
    @(negedge clk);
    hs_h[0] = hsync3; pc_h[0] = pclk3; la_h[0] = latch3; px_h[0] = px3;
    lcd_on3 = 1'b1;
    for (int c = 1; c < 15; c++) begin
      @(negedge clk);
      hs_h[c] = hsync3; pc_h[c] = pclk3; la_h[c] = latch3; px_h[c] = px3;
    end
    hs_f = -1; pc_f = -1; la_f = -1; hs_r = -1;
    for (int c = 1; c < 15; c++) begin
      if (hs_f < 0 && hs_h[c-1] && !hs_h[c]) hs_f = c;
      if (hs_f > 0 && pc_f < 0 && pc_h[c-1] && !pc_h[c] && !hs_h[c]) pc_f = c;
      if (la_f < 0 && la_h[c-1] && !la_h[c]) la_f = c;
      if (c > 1 && hs_r < 0 && !hs_h[c-1] && hs_h[c]) hs_r = c;
    end
    chk("n3_hsync_fall", hs_f, 4);
    chk("n3_pclk_fall", pc_f, 6);
    chk("n3_latch_fall", la_f, 8);
    chk("n3_line_period", hs_r - 1, 9);
    chk("n3_pixels", 32'({px_h[4], px_h[6], px_h[8]}), 32'({2'd0, 2'd1, 2'd2}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
